phase_sequencer: RTL and testbench
==================================

PHASE_SEQUENCER -- requirements
Module: phase_sequencer

Interface
REQ-001 SHALL have one clock; reset is asynchronous and active-low.
REQ-002 CP  in  1  clock; all state updates on the rising edge.
REQ-003 MR  in  1  asynchronous active-low master reset.
REQ-004 START  in  1  begin a sequence; sampled only in IDLE.
REQ-005 STOP  in  1  abort; sampled in every state.
REQ-006 A_VAL  in  4  phase-A load value, captured at accepted START.
REQ-007 B_VAL  in  4  phase-B load value, captured at accepted START.
REQ-008 NCYC  in  4  A+B periods to run, captured at accepted START; 0 = continuous.
REQ-009 TC1, TC2  in  1 each  terminal-count inputs from counter 1 and counter 2.
REQ-010 P  out  4  parallel data to both counters.
REQ-011 PE  out  1  active-low parallel load, shared by both counters.
REQ-012 CEP, CET  out  1 each  active-high count enables, shared by both counters.
REQ-013 SR1, SR2  out  1 each  active-low synchronous resets, one per counter.
REQ-014 PHASE  out  1  0 while in phase A, 1 while in phase B.
REQ-015 BUSY  out  1  high in any state other than IDLE.
REQ-016 DONE  out  1  one-cycle pulse on normal completion.
REQ-017 CYC_CNT  out  4  number of completed A+B periods.

Function
REQ-018 Controlled counter behaviour: each counter is 4-bit; priority is SR, then PE load, then count when CEP&CET; TC = CET & (Q==15).
REQ-019 FSM SHALL have states IDLE, LOAD_A, RUN_A, LOAD_B, RUN_B.
REQ-020 P, PE, CEP, CET, SR1, SR2, PHASE and BUSY SHALL be Moore decodes of the state register, with no added latency.
REQ-021 IDLE drive: SR1=SR2=0, PE=1, CEP=CET=0, P=0.
REQ-022 LOAD_A drive: P=A_VAL reg, PE=0, SR1=1, SR2=0, CEP=CET=1.
REQ-023 RUN_A drive: PE=1, SR1=1, SR2=0, CEP=CET=1.
REQ-024 LOAD_B and RUN_B SHALL mirror LOAD_A and RUN_A, using B_VAL reg with SR1=0 and SR2=1.
REQ-025 Transitions: IDLE & START -> LOAD_A; LOAD_A -> RUN_A; RUN_A & TC1 -> LOAD_B; LOAD_B -> RUN_B.
REQ-026 In RUN_B & TC2, CYC_CNT SHALL increment (wrapping mod 16); next state is IDLE if NCYC!=0 and the incremented count equals NCYC, otherwise LOAD_A.
REQ-027 Resulting phase lengths: phase A = 17-A_VAL cycles and phase B = 17-B_VAL cycles (range 2..17 each).
REQ-028 DONE SHALL be a registered pulse, high in the first IDLE cycle after completion only.
REQ-029 STOP in any non-IDLE state SHALL force IDLE on the next edge, with no DONE pulse and CYC_CNT held.
REQ-030 STOP and START in the same IDLE cycle: STOP wins, and the FSM stays in IDLE.
REQ-031 START outside IDLE SHALL be ignored.
REQ-032 TC1 outside RUN_A and TC2 outside RUN_B SHALL be ignored.
REQ-033 An accepted START SHALL clear CYC_CNT to 0 and capture A_VAL, B_VAL and NCYC.
REQ-034 With NCYC=0, the block SHALL run until STOP, with CYC_CNT wrapping 15->0.

Reset
REQ-035 MR low SHALL immediately set: state IDLE, CYC_CNT=0, DONE=0, and the captured A_VAL/B_VAL/NCYC registers to 0.
REQ-036 While MR is low, the outputs SHALL equal the IDLE drive, so both counters clear on the next CP edge.
REQ-037 MR asserted mid-sequence SHALL abort with no DONE pulse; operation resumes only on a fresh START after release.

Structure
REQ-038 Shared package counter_seq_pkg SHALL hold the state enum, CNT_W=4, and the TC_VALUE=15 constant.
REQ-039 The block SHALL have no sub-module; the bench SHALL wrap phase_sequencer with the existing two-counter unit on common CP.

Verification
REQ-040 Nominal run: MR release, then START with A=12, B=14, NCYC=2 -> PHASE low 5 cycles, high 3 cycles, twice; DONE 16 cycles after the START edge; CYC_CNT=2.
REQ-041 Minimum phase: A=15, B=15, NCYC=1 -> each phase 2 cycles; DONE 4 cycles after START.
REQ-042 Continuous: A=0, B=0, NCYC=0, run 20 periods -> each phase 17 cycles; CYC_CNT wraps to 4; no DONE.
REQ-043 Abort: STOP at the third RUN_B cycle -> IDLE next edge; SR1=SR2=0; Q1=Q2=0 one edge later; no DONE.
REQ-044 Async reset: MR low mid-RUN_A, between edges -> BUSY=0 and SR1=SR2=0 immediately; START during BUSY ignored; STOP+START together in IDLE -> stays IDLE.

Source files
------------

// File: rtl/counter_seq_pkg.sv
// Shared types and constants for the phase sequencer and the 4-bit counters it steers.
package counter_seq_pkg;

  localparam int CNT_W = 4;
  localparam logic [CNT_W-1:0] TC_VALUE = 4'd15;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    LOAD_A = 3'd1,
    RUN_A  = 3'd2,
    LOAD_B = 3'd3,
    RUN_B  = 3'd4
  } state_e;

endpackage

// File: rtl/phase_sequencer.sv
// Alternates two external loadable counters through phase A and phase B,
// repeating for a captured number of periods (or forever) and pulsing DONE at the end.
module phase_sequencer
  import counter_seq_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             stop_i,
  input  logic [CNT_W-1:0] a_val_i,
  input  logic [CNT_W-1:0] b_val_i,
  input  logic [CNT_W-1:0] ncyc_i,
  input  logic             tc1_i,
  input  logic             tc2_i,
  output logic [CNT_W-1:0] p_o,
  output logic             pe_o,
  output logic             cep_o,
  output logic             cet_o,
  output logic             sr1_o,
  output logic             sr2_o,
  output logic             phase_o,
  output logic             busy_o,
  output logic             done_o,
  output logic [CNT_W-1:0] cyc_cnt_o
);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] a_q, a_d;
  logic [CNT_W-1:0] b_q, b_d;
  logic [CNT_W-1:0] ncyc_q, ncyc_d;
  logic [CNT_W-1:0] cyc_q, cyc_d;
  logic [CNT_W-1:0] cyc_inc;
  logic             done_q, done_d;

  assign cyc_inc = cyc_q + 1'b1;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      a_q     <= '0;
      b_q     <= '0;
      ncyc_q  <= '0;
      cyc_q   <= '0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      ncyc_q  <= ncyc_d;
      cyc_q   <= cyc_d;
      done_q  <= done_d;
    end
  end

  // STOP overrides everything, so an abort never counts a period or pulses DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    ncyc_d  = ncyc_q;
    cyc_d   = cyc_q;
    done_d  = 1'b0;
    if (stop_i) begin
      state_d = IDLE;
    end else begin
      unique case (state_q)
        IDLE: begin
          if (start_i) begin
            state_d = LOAD_A;
            a_d     = a_val_i;
            b_d     = b_val_i;
            ncyc_d  = ncyc_i;
            cyc_d   = '0;
          end
        end
        LOAD_A: state_d = RUN_A;
        RUN_A:  if (tc1_i) state_d = LOAD_B;
        LOAD_B: state_d = RUN_B;
        RUN_B: begin
          if (tc2_i) begin
            cyc_d = cyc_inc;
            if ((ncyc_q != '0) && (cyc_inc == ncyc_q)) begin
              state_d = IDLE;
              done_d  = 1'b1;
            end else begin
              state_d = LOAD_A;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Pure state decode: during reset the state is IDLE, so both counters are held clear.
  always_comb begin
    p_o     = '0;
    pe_o    = 1'b1;
    cep_o   = 1'b0;
    cet_o   = 1'b0;
    sr1_o   = 1'b0;
    sr2_o   = 1'b0;
    phase_o = 1'b0;
    busy_o  = 1'b1;
    unique case (state_q)
      IDLE: busy_o = 1'b0;
      LOAD_A, RUN_A: begin
        p_o   = a_q;
        pe_o  = (state_q != LOAD_A);
        cep_o = 1'b1;
        cet_o = 1'b1;
        sr1_o = 1'b1;
      end
      LOAD_B, RUN_B: begin
        p_o     = b_q;
        pe_o    = (state_q != LOAD_B);
        cep_o   = 1'b1;
        cet_o   = 1'b1;
        sr2_o   = 1'b1;
        phase_o = 1'b1;
      end
      default: busy_o = 1'b0;
    endcase
  end

  assign done_o    = done_q;
  assign cyc_cnt_o = cyc_q;

endmodule

// File: tb/tb_phase_sequencer.sv
// Bench: phase_sequencer driving two behavioural 4-bit counters, checked cycle by
// cycle against a period-arithmetic model of the phase timing.
module tb_phase_sequencer;
  import counter_seq_pkg::*;

  logic       clk;
  logic       rst_n;
  logic       start, stop;
  logic [3:0] a_val, b_val, ncyc;
  logic       tc1, tc2;
  logic [3:0] p;
  logic       pe, cep, cet, sr1, sr2, phase, busy, done;
  logic [3:0] cyc_cnt;
  logic [3:0] q1, q2;

  int checks = 0;
  int failures = 0;

  typedef struct packed {
    logic [3:0] p;
    logic       pe, cep, cet, sr1, sr2, phase, busy, done;
    logic [3:0] cyc;
  } outs_t;

  typedef struct {
    int a, b, n;
    int expDoneAt;
    int expCyc;
  } vec_t;

  phase_sequencer dut (
    .clk_i(clk), .rst_ni(rst_n), .start_i(start), .stop_i(stop),
    .a_val_i(a_val), .b_val_i(b_val), .ncyc_i(ncyc),
    .tc1_i(tc1), .tc2_i(tc2),
    .p_o(p), .pe_o(pe), .cep_o(cep), .cet_o(cet), .sr1_o(sr1), .sr2_o(sr2),
    .phase_o(phase), .busy_o(busy), .done_o(done), .cyc_cnt_o(cyc_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The two-counter unit: SR beats PE load, which beats counting.
  always_ff @(posedge clk) begin
    if (!sr1) q1 <= '0;
    else if (!pe) q1 <= p;
    else if (cep && cet) q1 <= q1 + 4'd1;
    if (!sr2) q2 <= '0;
    else if (!pe) q2 <= p;
    else if (cep && cet) q2 <= q2 + 4'd1;
  end
  assign tc1 = cet && (q1 == TC_VALUE);
  assign tc2 = cet && (q2 == TC_VALUE);

  function automatic outs_t idleExp(input int cyc, input bit dn);
    outs_t e;
    e = '0;
    e.pe = 1'b1;
    e.cyc = 4'(cyc);
    e.done = dn;
    return e;
  endfunction

  // t = cycles since the accepted START edge; each period is (17-a)+(17-b) cycles.
  function automatic outs_t modelOut(input int a, input int b, input int n, input int t);
    outs_t e;
    int la, lb, per, r;
    la = 17 - a;
    lb = 17 - b;
    per = la + lb;
    if (n != 0 && t >= n * per) return idleExp(n, t == n * per);
    r = t % per;
    e = '0;
    e.busy = 1'b1;
    e.cep = 1'b1;
    e.cet = 1'b1;
    e.cyc = 4'((t / per) % 16);
    if (r < la) begin
      e.sr1 = 1'b1;
      e.pe = (r != 0);
      e.p = 4'(a);
    end else begin
      e.sr2 = 1'b1;
      e.phase = 1'b1;
      e.pe = (r != la);
      e.p = 4'(b);
    end
    return e;
  endfunction

  task automatic checkOutput(input string name, input outs_t expIn, input int t);
    outs_t act, e;
    e = expIn;
    act = {p, pe, cep, cet, sr1, sr2, phase, busy, done, cyc_cnt};
    // P is only meaningful while loading or idle
    if (e.pe && e.busy) begin
      act.p = '0;
      e.p = '0;
    end
    checks++;
    if (act !== e) begin
      failures++;
      $display("[TB] FAIL %s t=%0d got=%h expected=%h", name, t, act, e);
    end
  endtask

  task automatic checkValue(input string name, input int actual, input int expected);
    checks++;
    if (actual != expected) begin
      failures++;
      $display("[TB] FAIL %s got=%0d expected=%0d", name, actual, expected);
    end
  endtask

  // Starts a sequence and checks every following cycle; STOP is raised in cycle stopAt.
  task automatic applyStimulus(input int a, input int b, input int n, input int stopAt,
                               input int cycles, input bit noise, output int doneAt);
    outs_t e;
    bit stopped;
    int cycHold;
    doneAt = -1;
    stopped = 0;
    cycHold = 0;
    @(negedge clk);
    a_val = 4'(a); b_val = 4'(b); ncyc = 4'(n); start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    a_val = 4'($urandom); b_val = 4'($urandom); ncyc = 4'($urandom);
    for (int t = 0; t < cycles; t++) begin
      e = stopped ? idleExp(cycHold, 1'b0) : modelOut(a, b, n, t);
      checkOutput("seq", e, t);
      if (done && doneAt < 0) doneAt = t;
      stop = (t == stopAt);
      if (stop && e.busy && !stopped) begin
        stopped = 1;
        cycHold = int'(e.cyc);
      end
      start = noise && e.busy && ($urandom_range(3) == 0);
      if (start) begin
        a_val = 4'($urandom); b_val = 4'($urandom); ncyc = 4'($urandom);
      end
      @(posedge clk); #1;
      stop = 1'b0;
      start = 1'b0;
    end
  endtask

  vec_t vecs[5];
  int doneAt;

  initial begin
    start = 0; stop = 0; a_val = 0; b_val = 0; ncyc = 0;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #1 checkOutput("resetDrive", idleExp(0, 1'b0), 0);
    repeat (2) @(posedge clk);
    #1 checkValue("resetClearsCounters", int'({q1, q2}), 0);
    @(negedge clk) rst_n = 1'b1;

    vecs[0] = '{a: 12, b: 14, n: 2, expDoneAt: 16, expCyc: 2};
    vecs[1] = '{a: 15, b: 15, n: 1, expDoneAt: 4,  expCyc: 1};
    vecs[2] = '{a: 0,  b: 15, n: 1, expDoneAt: 19, expCyc: 1};
    vecs[3] = '{a: 7,  b: 3,  n: 3, expDoneAt: 72, expCyc: 3};
    vecs[4] = '{a: 9,  b: 1,  n: 4, expDoneAt: 96, expCyc: 4};
    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].n, -1, vecs[i].expDoneAt + 3, 1'b1, doneAt);
      checkValue("doneLatency", doneAt, vecs[i].expDoneAt);
      checkValue("finalCycCnt", int'(cyc_cnt), vecs[i].expCyc);
    end

    $display("[TB] continuous run, 20 periods of 34 cycles");
    applyStimulus(0, 0, 0, 680, 681, 1'b1, doneAt);
    checkValue("continuousNoDone", doneAt, -1);
    checkValue("continuousWrap", int'(cyc_cnt), 4);

    // Abort in the third RUN_B cycle: phase A is 5 cycles, so that is t=8.
    applyStimulus(12, 10, 2, 8, 9, 1'b0, doneAt);
    checkValue("abortSr", int'({sr1, sr2, busy, done}), 0);
    @(posedge clk); #1;
    checkValue("abortCounters", int'({q1, q2}), 0);
    checkValue("abortNoDone", int'(done), 0);

    // Asynchronous reset between edges while in RUN_A.
    applyStimulus(3, 5, 0, -1, 4, 1'b0, doneAt);
    #3 rst_n = 1'b0;
    #1 checkOutput("asyncReset", idleExp(0, 1'b0), 0);
    @(negedge clk) rst_n = 1'b1;
    repeat (3) @(posedge clk);
    #1 checkOutput("noResumeAfterReset", idleExp(0, 1'b0), 0);

    @(negedge clk);
    a_val = 4'd14; b_val = 4'd14; ncyc = 4'd1; start = 1'b1; stop = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; stop = 1'b0;
    checkOutput("stopBeatsStart", idleExp(0, 1'b0), 0);

    for (int k = 0; k < 10; k++) begin
      int a, b, n, per, stopAt, cycles;
      a = $urandom_range(15, 8);
      b = $urandom_range(15, 8);
      n = $urandom_range(3, 0);
      per = 34 - a - b;
      if (n == 0) begin
        stopAt = $urandom_range(50, 3);
        cycles = stopAt + 3;
      end else begin
        stopAt = ($urandom_range(1, 0) == 1) ? $urandom_range(n * per + 1, 0) : -1;
        cycles = n * per + 3;
      end
      applyStimulus(a, b, n, stopAt, cycles, 1'b1, doneAt);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
